// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between the datapath and the MD unit.
// The master issues ops; the slave (md_unit) returns busy and HI/LO.
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, A, B,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, A, B,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers.
// Result is computed at acceptance and released after a fixed latency.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic     clk,
  input logic     rst,
  md_unit_if.slave md
);

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] phi_q, plo_q;
  logic        pwe_q;

  logic        is_md, is_div, is_sgn;
  logic        accept, done, wr_hi, wr_lo;
  logic [31:0] phi_d, plo_d;
  logic        pwe_d;

  logic [63:0] ax, bx, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag;

  assign is_md  = (md.op[2] == 1'b0);
  assign is_div = md.op[1];
  assign is_sgn = ~md.op[0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: start only matters in IDLE, RUN ends on last count
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (md.start && is_md) state_d = RUN;
      RUN:  if (cnt_q == 4'd1)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes decoded from state and request
  always_comb begin
    accept = (state_q == IDLE) && md.start;
    done   = (state_q == RUN) && (cnt_q == 4'd1);
    wr_hi  = accept && (md.op == 3'd4);
    wr_lo  = accept && (md.op == 3'd5);
  end

  // Result datapath: whole result computed from the accepted operands
  always_comb begin
    ax     = is_sgn ? {{32{md.A[31]}}, md.A} : {32'b0, md.A};
    bx     = is_sgn ? {{32{md.B[31]}}, md.B} : {32'b0, md.B};
    prod   = ax * bx;
    a_neg  = is_sgn & md.A[31];
    b_neg  = is_sgn & md.B[31];
    a_mag  = a_neg ? -md.A : md.A;
    b_mag  = b_neg ? -md.B : md.B;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    if (is_div) begin
      plo_d = (a_neg ^ b_neg) ? -q_mag : q_mag;
      phi_d = a_neg ? -r_mag : r_mag;
      pwe_d = (md.B != 32'd0);
    end else begin
      plo_d = prod[31:0];
      phi_d = prod[63:32];
      pwe_d = 1'b1;
    end
  end

  // Latency counter and pending result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
      phi_q <= 32'd0;
      plo_q <= 32'd0;
      pwe_q <= 1'b0;
    end else if (accept && is_md) begin
      cnt_q <= is_div ? DIV_N : MUL_N;
      phi_q <= phi_d;
      plo_q <= plo_d;
      pwe_q <= pwe_d;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Architectural HI/LO: completion commit or MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (done) begin
      if (pwe_q) begin
        hi_q <= phi_q;
        lo_q <= plo_q;
      end
    end else begin
      if (wr_hi) hi_q <= md.A;
      if (wr_lo) lo_q <= md.A;
    end
  end

  assign md.busy = (state_q == RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: vector table, corner sequences and random ops
// against an arithmetic reference model of HI/LO and busy.
module tb_md_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  md_unit_if bus();

  md_unit #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .md (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0;
  logic [31:0] p_lo = 32'd0;
  bit          p_we = 1'b0;
  int          m_left = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void ref_result(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rh,
    output logic [31:0] rl,
    output bit          we);
    longint sa, sb, q, r;
    logic [63:0] p;
    we = 1'b1;
    rh = 32'd0;
    rl = 32'd0;
    if (op == 3'd0 || op == 3'd2) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    if (op[1] == 1'b0) begin
      p  = 64'(sa * sb);
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 32'd0) begin
      we = 1'b0;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rl = q[31:0];
      rh = r[31:0];
    end
  endfunction

  task automatic model_edge(input logic s, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic r);
    if (r) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_left = 0;
      p_we = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_we) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (s) begin
      if (o < 3'd4) begin
        ref_result(o, a, b, p_hi, p_lo, p_we);
        m_left = o[1] ? DIV_N : MUL_N;
      end else if (o == 3'd4) begin
        m_hi = a;
      end else if (o == 3'd5) begin
        m_lo = a;
      end
    end
  endtask

  task automatic cyc(input logic s, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic r);
    bus.start = s;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    rst       = r;
    model_edge(s, o, a, b, r);
    @(posedge clk);
    #1;
    chk("m_busy", {31'b0, bus.busy}, {31'b0, (m_left > 0)});
    chk("m_hi", bus.hi, m_hi);
    chk("m_lo", bus.lo, m_lo);
  endtask

  task automatic idle();
    cyc(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 40) begin
      idle();
      k++;
    end
    chk("drain", {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    logic [2:0] o;
    logic s, r;
    int sel;

    tbl[0] = '{3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tbl[1] = '{3'd1, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 5};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3] = '{3'd3, 32'h7, 32'h2, 32'h1, 32'h3, 10};
    tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10};
    tbl[5] = '{3'd4, 32'h1234, 32'h0, 32'h1234, 32'h80000000, 0};
    tbl[6] = '{3'd5, 32'h5678, 32'h0, 32'h1234, 32'h5678, 0};
    tbl[7] = '{3'd3, 32'hDEAD, 32'h0, 32'h1234, 32'h5678, 10};
    tbl[8] = '{3'd6, 32'hFFFF, 32'h1, 32'h1234, 32'h5678, 0};
    tbl[9] = '{3'd7, 32'hFFFF, 32'h1, 32'h1234, 32'h5678, 0};

    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    rst       = 1'b1;

    cyc(1'b1, 3'd0, 32'd5, 32'd7, 1'b1);
    cyc(1'b1, 3'd0, 32'd5, 32'd7, 1'b1);
    cyc(1'b0, 3'd0, 32'd5, 32'd7, 1'b0);
    chk("reset_busy", {31'b0, bus.busy}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);

    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
        n++;
        idle();
      end
      chk($sformatf("vec%0d_busy", i), 32'(n), 32'(tbl[i].n));
      chk($sformatf("vec%0d_hi", i), bus.hi, tbl[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.lo, tbl[i].lo);
    end

    cyc(1'b1, 3'd0, 32'd3, 32'd5, 1'b0);
    n = int'(bus.busy);
    cyc(1'b1, 3'd4, 32'hAAAA, 32'd0, 1'b0);
    n += int'(bus.busy);
    cyc(1'b1, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    n += int'(bus.busy);
    while (bus.busy === 1'b1 && n < 40) begin
      idle();
      n += int'(bus.busy);
    end
    chk("ovl_busy", 32'(n), 32'(MUL_N));
    chk("ovl_hi", bus.hi, 32'd0);
    chk("ovl_lo", bus.lo, 32'd15);
    cyc(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    chk("b2b_busy", {31'b0, bus.busy}, 32'd1);
    drain();
    chk("b2b_hi", bus.hi, 32'd2);
    chk("b2b_lo", bus.lo, 32'd14);

    cyc(1'b1, 3'd4, 32'd1, 32'd0, 1'b0);
    cyc(1'b1, 3'd5, 32'd2, 32'd0, 1'b0);
    cyc(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    idle();
    idle();
    idle();
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    for (int i = 0; i < 12; i++) begin
      idle();
      chk("midrst_late", bus.hi | bus.lo, 32'd0);
    end

    for (int i = 0; i < 600; i++) begin
      s   = ($urandom_range(0, 2) != 0);
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      if (sel == 2) b = 32'($urandom_range(1, 9));
      r = ($urandom_range(0, 79) == 0);
      cyc(s, o, a, b, r);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit fed by the datapath's register-file read ports (rs → A, rt → B), alongside the ALU.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and holds results in architectural HI/LO registers.
- Also executes single-cycle MTHI/MTLO writes.
- Exports busy so the controller stalls MFHI/MFLO and further MD ops while an operation is in flight.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request: execute op this cycle
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved
- A  input  32  operand from GRF RD1 (rs)
- B  input  32  operand from GRF RD2 (rt)
- busy  output  1  multi-cycle op in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: clk and rst only. rst=1 at a rising edge forces busy=0, hi=0, lo=0, counter=0, pending results=0. rst overrides start in the same cycle. rst mid-operation aborts the op with no HI/LO update.
- State machine:
  - IDLE (busy=0) → RUN (busy=1) on an accepted MULT/MULTU/DIV/DIVU.
  - RUN → IDLE when the counter expires.
- Acceptance: start is sampled only in IDLE. start while busy=1 is ignored entirely (no queueing); the controller must hold it off. Reserved op with start=1: ignored, no state change.
- MTHI/MTLO, IDLE and start=1: hi (resp. lo) ← A at that edge. busy stays 0. The other register is unchanged.
- Multi-cycle ops, accepting edge E0:
  - The result is computed from A/B sampled at E0 and held in internal pending registers. Later changes to A/B have no effect.
  - Counter loads N (MUL_CYCLES or DIV_CYCLES); busy=1 from E0 until edge E0+N.
  - At edge E0+N, hi/lo ← pending and busy → 0 simultaneously.
  - hi/lo keep their old values throughout RUN.
  - A new start may be accepted at the cycle immediately after busy falls (back-to-back, no bubble inside the unit).
- Arithmetic:
  - MULT: signed 32×32 → 64; hi = product[63:32], lo = product[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend (A).
  - DIVU: unsigned quotient/remainder.
  - DIV with A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0x00000000, no trap.
  - Divide by zero (B=0, DIV or DIVU): the full busy period still elapses, but hi/lo are NOT updated at completion (retain prior values).
- Outputs hi, lo and busy are registered (no combinational path from inputs).
- The implementation may compute the result in one cycle or iteratively, provided the externally visible timing above is exact.

Test Plan:
- Reset: drive rst=1 for 2 cycles with start=1, op=0 → busy=0, hi=0, lo=0 after release; no op begins.
- MULT, A=0xFFFFFFFE (-2), B=0x00000003, start for 1 cycle:
  - busy=1 for exactly 5 cycles.
  - hi/lo unchanged until busy falls.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV, A=0xFFFFFFF9 (-7), B=2:
  - busy for 10 cycles.
  - Then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU 7/2 → lo=3, hi=1.
- Boundary divides:
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - After MTHI 0x1234 and MTLO 0x5678, DIVU by B=0 → busy 10 cycles, then hi=0x1234, lo=0x5678.
- Overlapping and back-to-back requests:
  - start MULT, then assert start MTHI A=0xAAAA and MULTU during busy → both ignored; hi/lo reflect the first MULT only.
  - start=1 on the first idle cycle → accepted.
- Reset mid-op: start DIV, assert rst in busy cycle 4 → next edge busy=0, hi=lo=0; no late update at the original completion edge.
